// File: rtl/sdm_pkg.sv
// Shared types for the sigma-delta transmit chain.
//   sample_t : 16-bit signed baseband/modulator sample
//   mode_e   : interpolator output shaping
//   state_e  : interpolator control state
package sdm_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_LINEAR = 2'd2
  } mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/interp_step_acc.sv
// Linear-interpolation accumulator.
//   clk, rst  : clock, synchronous active-high reset
//   load      : acc <= base <<< S, delta latched
//   step      : acc <= acc + delta
//   base      : previous sample (phase-0 value)
//   delta     : cur - prev, 17-bit signed
//   next_val  : (acc + delta) >>> S, i.e. the value of the following phase
module interp_step_acc #(
  parameter int unsigned S = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] base,
  input  logic [16:0] delta,
  output logic [15:0] next_val
);

  localparam int unsigned AccW = 17 + S;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] delta_ext;
  logic signed [AccW-1:0] sum;
  logic signed [16:0]     delta_q, delta_d;

  always_comb begin
    delta_ext = {{S{delta_q[16]}}, delta_q};
    sum       = acc_q + delta_ext;
    // Arithmetic shift floors toward -inf; result always lies between prev and cur.
    next_val  = 16'(sum >>> S);
    acc_d     = acc_q;
    delta_d   = delta_q;
    if (load) begin
      acc_d   = $signed({{(S + 1){base[15]}}, base}) <<< S;
      delta_d = delta;
    end else if (step) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      delta_q <= '0;
    end else begin
      acc_q   <= acc_d;
      delta_q <= delta_d;
    end
  end

endmodule

// File: rtl/upsample_interp.sv
// Integer-factor interpolator: one input sample in, UPSAMPLE_FACTOR samples out
// (zero-stuffed, held or linearly interpolated), each paced by ready_out.
//   clk, rst              : clock, synchronous active-high reset
//   valid_in/ready_in     : input handshake, in_signal 16-bit signed
//   valid_out/ready_out   : output handshake, out_signal 16-bit signed (registered)
module upsample_interp
  import sdm_pkg::*;
#(
  parameter int unsigned UPSAMPLE_FACTOR = 64,
  parameter int unsigned MODE            = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [15:0] in_signal,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [15:0] out_signal
);

  localparam int unsigned S         = $clog2(UPSAMPLE_FACTOR);
  localparam logic [S-1:0] LastPhase = S'(UPSAMPLE_FACTOR - 1);
  localparam mode_e       Mode      = mode_e'(MODE[1:0]);

  if (UPSAMPLE_FACTOR < 2 || UPSAMPLE_FACTOR > 256 ||
      (UPSAMPLE_FACTOR & (UPSAMPLE_FACTOR - 1)) != 0 || MODE > 2) begin : g_param_err
    $error("upsample_interp: UPSAMPLE_FACTOR must be a power of two in 2..256, MODE <= 2");
  end

  state_e       state_q, state_d;
  sample_t      cur_q, cur_d;
  sample_t      prev_q, prev_d;
  sample_t      out_q, out_d;
  logic [S-1:0] phase_q, phase_d;

  logic         xfer, last, accept;
  sample_t      prev_eff;
  logic [16:0]  delta_ld;
  logic [15:0]  acc_next;

  always_comb begin
    xfer     = (state_q == StRun) && ready_out;
    last     = (phase_q == LastPhase);
    // Open on the final transfer so the next sample loads without a bubble.
    ready_in = !rst && ((state_q == StIdle) || (last && ready_out));
    accept   = valid_in && ready_in;
    // On a back-to-back load the just-finished cur becomes prev in the same edge.
    prev_eff = (xfer && last) ? cur_q : prev_q;
    delta_ld = {in_signal[15], in_signal} - {prev_eff[15], prev_eff};

    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    out_d   = out_q;
    phase_d = phase_q;

    if (xfer && last) begin
      prev_d  = cur_q;
      state_d = StIdle;
    end

    if (xfer && !last) begin
      phase_d = phase_q + S'(1);
      if (Mode == MODE_ZERO) begin
        out_d = '0;
      end else if (Mode == MODE_HOLD) begin
        out_d = cur_q;
      end else begin
        out_d = sample_t'(acc_next);
      end
    end

    if (accept) begin
      cur_d   = sample_t'(in_signal);
      phase_d = '0;
      state_d = StRun;
      out_d   = (Mode == MODE_LINEAR) ? prev_eff : sample_t'(in_signal);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      out_q   <= out_d;
      phase_q <= phase_d;
    end
  end

  if (MODE == 2) begin : g_lin
    interp_step_acc #(
      .S(S)
    ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (xfer && !last),
      .base    (prev_eff),
      .delta   (delta_ld),
      .next_val(acc_next)
    );
  end else begin : g_nolin
    assign acc_next = '0;
  end

  assign valid_out  = (state_q == StRun);
  assign out_signal = out_q;

endmodule

// File: tb/tb_upsample_interp.sv
// Directed bench for upsample_interp: four instances cover hold, zero-stuff,
// linear (L=4, also reset and backpressure) and linear extremes (L=2).
module tb_upsample_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic        vi [4];
  logic        ri [4];
  logic [15:0] si [4];
  logic        vo [4];
  logic        ro [4];
  logic [15:0] so [4];

  int obs [4][$];
  int n_vec = 0;
  int n_err = 0;
  bit bp_on = 1'b0;

  // monitor state for the linear L=4 instance
  int bc = 0;
  bit stall_prev = 1'b0;
  int stall_val = 0;

  always #5 clk = ~clk;

  upsample_interp #(.UPSAMPLE_FACTOR(4), .MODE(1)) u_hold (
    .clk(clk), .rst(rst), .valid_in(vi[0]), .ready_in(ri[0]), .in_signal(si[0]),
    .valid_out(vo[0]), .ready_out(ro[0]), .out_signal(so[0]));
  upsample_interp #(.UPSAMPLE_FACTOR(4), .MODE(0)) u_zero (
    .clk(clk), .rst(rst), .valid_in(vi[1]), .ready_in(ri[1]), .in_signal(si[1]),
    .valid_out(vo[1]), .ready_out(ro[1]), .out_signal(so[1]));
  upsample_interp #(.UPSAMPLE_FACTOR(4), .MODE(2)) u_lin (
    .clk(clk), .rst(rst), .valid_in(vi[2]), .ready_in(ri[2]), .in_signal(si[2]),
    .valid_out(vo[2]), .ready_out(ro[2]), .out_signal(so[2]));
  upsample_interp #(.UPSAMPLE_FACTOR(2), .MODE(2)) u_ext (
    .clk(clk), .rst(rst), .valid_in(vi[3]), .ready_in(ri[3]), .in_signal(si[3]),
    .valid_out(vo[3]), .ready_out(ro[3]), .out_signal(so[3]));

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input int d, input string tag, input int e);
    if (obs[d].size() == 0) check_val(tag, -100000, e);
    else check_val(tag, obs[d].pop_front(), e);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input int d, input logic [15:0] s, output int waited);
    bit done = 1'b0;
    waited = -1;
    vi[d] = 1'b1;
    si[d] = s;
    for (int t = 0; t < 300 && !done; t++) begin
      #2;
      if (ri[d]) begin
        done = 1'b1;
        waited = t;
      end
      @(negedge clk);
    end
    vi[d] = 1'b0;
    if (!done) check_val("send_timeout", 0, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) obs[d].delete();
  endtask

  // Transfer monitor: samples 3 time units after the negedge, before the next posedge.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      bc = 0;
      stall_prev = 1'b0;
    end else begin
      for (int d = 0; d < 4; d++)
        if (vo[d] && ro[d]) obs[d].push_back(int'($signed(so[d])));
      if (stall_prev) begin
        check_val("stall_valid", int'(vo[2]), 1);
        check_val("stall_data", int'($signed(so[2])), stall_val);
      end
      stall_prev = vo[2] && !ro[2];
      stall_val  = int'($signed(so[2]));
      if (vo[2] && ri[2]) check_val("ri_midburst", int'(bc == 3 && ro[2]), 1);
      if (vo[2] && ro[2]) bc++;
      if (vi[2] && ri[2]) bc = 0;
    end
  end

  always begin
    @(negedge clk);
    if (bp_on) ro[2] = ($urandom_range(0, 9) < 3);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ex [$];
    int prev_m;
    int samples [8] = '{1000, -1000, 37, -5, 32767, -32768, 12345, 0};
    int e_hold [8]  = '{100, 100, 100, 100, -200, -200, -200, -200};
    int e_zero [8]  = '{7, 0, 0, 0, -3, 0, 0, 0};
    int e_lin [12]  = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 200, 0, -200};
    int e_ext [4]   = '{0, 16383, 32767, -1};

    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      vi[d] = 1'b0;
      si[d] = '0;
      ro[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #2;
    check_val("rst_valid", int'(vo[0]), 0);
    check_val("rst_data", int'($signed(so[2])), 0);
    check_val("rst_ready", int'(ri[1]), 0);
    rst = 1'b0;
    #1;
    check_val("idle_ready", int'(ri[1]), 1);
    @(negedge clk);

    // Sample-and-hold, back-to-back.
    send(0, 16'd100, w);
    check_val("hold_first_wait", w, 0);
    send(0, -16'sd200, w);
    check_val("hold_gap", w, 3);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) expect_out(0, "hold_out", e_hold[i]);
    check_val("hold_extra", obs[0].size(), 0);

    // Zero-stuff.
    send(1, 16'd7, w);
    send(1, -16'sd3, w);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) expect_out(1, "zero_out", e_zero[i]);
    check_val("zero_extra", obs[1].size(), 0);

    // Reset in the middle of a linear burst.
    send(2, 16'd400, w);
    send(2, 16'd800, w);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      check_val("midrst_valid", int'(vo[2]), 0);
      check_val("midrst_data", int'($signed(so[2])), 0);
      check_val("midrst_ready", int'(ri[2]), 0);
    end
    rst = 1'b0;
    #1;
    check_val("postrst_ready", int'(ri[2]), 1);
    @(negedge clk);
    obs[2].delete();
    send(2, 16'd400, w);
    repeat (6) @(negedge clk);
    expect_out(2, "postrst_p0", 0);
    expect_out(2, "postrst_p1", 100);
    expect_out(2, "postrst_p2", 200);
    expect_out(2, "postrst_p3", 300);

    // Linear, L=4.
    reset_pulse();
    send(2, 16'd0, w);
    send(2, 16'd400, w);
    send(2, -16'sd400, w);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 12; i++) expect_out(2, "lin_out", e_lin[i]);
    check_val("lin_extra", obs[2].size(), 0);

    // Linear extremes, L=2.
    send(3, 16'h7fff, w);
    send(3, 16'h8000, w);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) expect_out(3, "ext_out", e_ext[i]);
    check_val("ext_extra", obs[3].size(), 0);

    // Backpressure against a direct-formula model.
    reset_pulse();
    prev_m = 0;
    foreach (samples[j]) begin
      for (int k = 0; k < 4; k++)
        ex.push_back((prev_m * 4 + k * (samples[j] - prev_m)) >>> 2);
      prev_m = samples[j];
    end
    bp_on = 1'b1;
    foreach (samples[j]) send(2, samples[j][15:0], w);
    for (int i = 0; i < 3000 && obs[2].size() < ex.size(); i++) @(negedge clk);
    bp_on = 1'b0;
    @(negedge clk);
    ro[2] = 1'b1;
    repeat (2) @(negedge clk);
    check_val("bp_count", obs[2].size(), ex.size());
    foreach (ex[i]) expect_out(2, "bp_out", ex[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
